// File: rtl/morse_pkg.sv
// Shared Morse constants: symbol event codes, timing unit multiples, ASCII bounds,
// and the encoder state type. Used by both the encoder and the decoder side.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_NONE = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_SEND = 2'b11
  } sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_LETTER_GAP,
    ST_WORD_GAP
  } state_t;

  localparam logic [2:0] MULT_DOT    = 3'd1;
  localparam logic [2:0] MULT_DASH   = 3'd3;
  localparam logic [2:0] MULT_ELEM   = 3'd1;
  localparam logic [2:0] MULT_LETTER = 3'd3;
  localparam logic [2:0] MULT_WORD   = 3'd7;

  localparam logic [7:0] ASCII_UC_LO    = 8'd65;
  localparam logic [7:0] ASCII_UC_HI    = 8'd90;
  localparam logic [7:0] ASCII_LC_LO    = 8'd97;
  localparam logic [7:0] ASCII_LC_HI    = 8'd122;
  localparam logic [7:0] ASCII_SPACE    = 8'd32;
  localparam logic [7:0] ASCII_CASE_OFS = 8'd32;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_LC_LO && c <= ASCII_LC_HI) return c - ASCII_CASE_OFS;
    return c;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character input handshake and keying/event outputs of the Morse encoder.
interface morse_encoder_if;
  import morse_pkg::*;

  // letter is taken on a rising edge where letter_valid and letter_ready are both 1;
  // letter_ready is 1 only while the encoder is idle, so anything offered while busy is ignored.
  logic [7:0] letter;
  logic       letter_valid;
  logic       letter_ready;
  logic       key;
  logic [1:0] symbol;
  logic       busy;
  logic       err;
  state_t     dbg_state;

  modport master (
    output letter, letter_valid,
    input  letter_ready, key, symbol, busy, err, dbg_state
  );

  modport slave (
    input  letter, letter_valid,
    output letter_ready, key, symbol, busy, err, dbg_state
  );

endinterface

// File: rtl/morse_lut.sv
// Uppercase ASCII to Morse element pattern: left-aligned in o_pattern (bit 3 first), 1 = dash.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [2:0] o_len,
  output logic [3:0] o_pattern,
  output logic       o_valid
);

  always_comb begin
    o_len     = 3'd0;
    o_pattern = 4'b0000;
    o_valid   = 1'b1;
    case (i_code)
      8'd65: {o_len, o_pattern} = {3'd2, 4'b0100}; // A .-
      8'd66: {o_len, o_pattern} = {3'd4, 4'b1000}; // B -...
      8'd67: {o_len, o_pattern} = {3'd4, 4'b1010}; // C -.-.
      8'd68: {o_len, o_pattern} = {3'd3, 4'b1000}; // D -..
      8'd69: {o_len, o_pattern} = {3'd1, 4'b0000}; // E .
      8'd70: {o_len, o_pattern} = {3'd4, 4'b0010}; // F ..-.
      8'd71: {o_len, o_pattern} = {3'd3, 4'b1100}; // G --.
      8'd72: {o_len, o_pattern} = {3'd4, 4'b0000}; // H ....
      8'd73: {o_len, o_pattern} = {3'd2, 4'b0000}; // I ..
      8'd74: {o_len, o_pattern} = {3'd4, 4'b0111}; // J .---
      8'd75: {o_len, o_pattern} = {3'd3, 4'b1010}; // K -.-
      8'd76: {o_len, o_pattern} = {3'd4, 4'b0100}; // L .-..
      8'd77: {o_len, o_pattern} = {3'd2, 4'b1100}; // M --
      8'd78: {o_len, o_pattern} = {3'd2, 4'b1000}; // N -.
      8'd79: {o_len, o_pattern} = {3'd3, 4'b1110}; // O ---
      8'd80: {o_len, o_pattern} = {3'd4, 4'b0110}; // P .--.
      8'd81: {o_len, o_pattern} = {3'd4, 4'b1101}; // Q --.-
      8'd82: {o_len, o_pattern} = {3'd3, 4'b0100}; // R .-.
      8'd83: {o_len, o_pattern} = {3'd3, 4'b0000}; // S ...
      8'd84: {o_len, o_pattern} = {3'd1, 4'b1000}; // T -
      8'd85: {o_len, o_pattern} = {3'd3, 4'b0010}; // U ..-
      8'd86: {o_len, o_pattern} = {3'd4, 4'b0001}; // V ...-
      8'd87: {o_len, o_pattern} = {3'd3, 4'b0110}; // W .--
      8'd88: {o_len, o_pattern} = {3'd4, 4'b1001}; // X -..-
      8'd89: {o_len, o_pattern} = {3'd4, 4'b1011}; // Y -.--
      8'd90: {o_len, o_pattern} = {3'd4, 4'b1100}; // Z --..
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one ASCII character at a time and plays it on key with
// unit-based timing, emitting one-cycle dot/dash/send events on symbol.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  morse_encoder_if.slave   bus
);

  localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);

  state_t      r_state, w_next_state;
  logic [15:0] r_unit_cnt;
  logic [2:0]  r_mult_cnt, r_elem_idx, r_len;
  logic [3:0]  r_pattern;
  logic        r_key, r_err;
  logic [1:0]  r_symbol;

  logic [7:0]  w_upper;
  logic [2:0]  w_lut_len, w_target;
  logic [3:0]  w_lut_pattern;
  logic        w_lut_valid, w_accept, w_is_space, w_unit_end, w_done, w_last_elem, w_next_err;
  logic [1:0]  w_next_sym;

  assign w_upper = to_upper(bus.letter);

  morse_lut u_lut (
    .i_code    (w_upper),
    .o_len     (w_lut_len),
    .o_pattern (w_lut_pattern),
    .o_valid   (w_lut_valid)
  );

  assign w_accept    = bus.letter_valid && (r_state == ST_IDLE);
  assign w_is_space  = (bus.letter == ASCII_SPACE);
  assign w_unit_end  = (r_unit_cnt == UNIT_LAST);
  assign w_done      = w_unit_end && (r_mult_cnt == w_target - 3'd1);
  assign w_last_elem = (r_elem_idx == r_len - 3'd1);

  // r_pattern[3] is always the element currently playing or about to play.
  always_comb begin
    w_target = MULT_DOT;
    case (r_state)
      ST_MARK:       w_target = r_pattern[3] ? MULT_DASH : MULT_DOT;
      ST_ELEM_GAP:   w_target = MULT_ELEM;
      ST_LETTER_GAP: w_target = MULT_LETTER;
      ST_WORD_GAP:   w_target = MULT_WORD;
      default:       w_target = MULT_DOT;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_sym   = SYM_NONE;
    w_next_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_space) begin
            w_next_state = ST_WORD_GAP;
          end else if (w_lut_valid) begin
            w_next_state = ST_MARK;
            w_next_sym   = w_lut_pattern[3] ? SYM_DASH : SYM_DOT;
          end else begin
            w_next_err = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (w_done) begin
          if (w_last_elem) begin
            w_next_state = ST_LETTER_GAP;
            w_next_sym   = SYM_SEND;
          end else begin
            w_next_state = ST_ELEM_GAP;
          end
        end
      end
      ST_ELEM_GAP: begin
        if (w_done) begin
          w_next_state = ST_MARK;
          w_next_sym   = r_pattern[3] ? SYM_DASH : SYM_DOT;
        end
      end
      ST_LETTER_GAP, ST_WORD_GAP: begin
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unit_cnt <= '0;
      r_mult_cnt <= '0;
      r_elem_idx <= '0;
      r_len      <= '0;
      r_pattern  <= '0;
      r_key      <= 1'b0;
      r_symbol   <= SYM_NONE;
      r_err      <= 1'b0;
    end else begin
      if ((w_next_state != r_state) || (r_state == ST_IDLE)) begin
        r_unit_cnt <= '0;
        r_mult_cnt <= '0;
      end else if (w_unit_end) begin
        r_unit_cnt <= '0;
        r_mult_cnt <= r_mult_cnt + 3'd1;
      end else begin
        r_unit_cnt <= r_unit_cnt + 16'd1;
      end
      if (r_state == ST_IDLE && w_next_state == ST_MARK) begin
        r_len      <= w_lut_len;
        r_pattern  <= w_lut_pattern;
        r_elem_idx <= '0;
      end else if (r_state == ST_MARK && w_next_state == ST_ELEM_GAP) begin
        r_pattern  <= {r_pattern[2:0], 1'b0};
        r_elem_idx <= r_elem_idx + 3'd1;
      end
      r_key    <= (w_next_state == ST_MARK);
      r_symbol <= w_next_sym;
      r_err    <= w_next_err;
    end
  end

  assign bus.letter_ready = (r_state == ST_IDLE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.key          = r_key;
  assign bus.symbol       = r_symbol;
  assign bus.err          = r_err;
  assign bus.dbg_state    = r_state;

endmodule
